// File: rtl/jtag_mem_pkg.sv
// Shared types and constants for the JTAG-to-memory bridge.
package jtag_mem_pkg;

  // Memory handshake states
  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ
  } req_state_t;

  // The sticky error flag sits in the MSB of the capture word
  function automatic int unsigned err_bit_pos(input int unsigned data_w);
    return data_w - 1;
  endfunction

  // Replicated across the whole word when a read word is not ready in time
  localparam logic UNDERRUN_FILL = 1'b1;

endpackage

// File: rtl/jtag_mem_req_fsm.sv
// Memory request/grant/rvalid handshake with one-word read buffer.
// A read request that cannot start immediately is held pending. A read
// that is still outstanding when the buffer is flushed is marked dropped,
// and its data is discarded when it arrives.
module jtag_mem_req_fsm
  import jtag_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_rd_start,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_wr_start,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_flush,
  output logic              o_idle,
  output logic              o_rbuf_valid,
  output logic [DATA_W-1:0] o_rbuf,
  output logic              o_rd_bypass,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic              i_mem_gnt,
  input  logic              i_mem_rvalid,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  req_state_t          r_state;
  req_state_t          w_state_nxt;
  logic                r_drop;
  logic                r_pend;
  logic [ADDR_W-1:0]   r_pend_addr;
  logic                r_rbuf_valid;
  logic [DATA_W-1:0]   r_rbuf;
  logic                r_req;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_be;

  logic                w_issue;
  logic                w_issue_we;
  logic                w_issue_pend;
  logic [ADDR_W-1:0]   w_issue_addr;
  logic                w_rd_done;
  logic                w_outstanding;

  assign w_rd_done     = (r_state == RD_WAIT) && i_mem_rvalid && !r_drop;
  assign w_outstanding = (r_state == RD_REQ) || (r_state == RD_WAIT);

  assign o_idle        = (r_state == IDLE);
  assign o_rbuf_valid  = r_rbuf_valid;
  assign o_rbuf        = r_rbuf;
  assign o_rd_bypass   = w_rd_done;
  assign o_mem_req     = r_req;
  assign o_mem_we      = r_we;
  assign o_mem_addr    = r_addr;
  assign o_mem_wdata   = r_wdata;
  assign o_mem_be      = r_be;

  // Next state and request launch decode
  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_we   = 1'b0;
    w_issue_pend = 1'b0;
    w_issue_addr = i_rd_addr;
    unique case (r_state)
      IDLE: begin
        if (i_wr_start) begin
          w_state_nxt  = WR_REQ;
          w_issue      = 1'b1;
          w_issue_we   = 1'b1;
          w_issue_addr = i_wr_addr;
        end else if (i_rd_start) begin
          w_state_nxt  = RD_REQ;
          w_issue      = 1'b1;
        end else if (r_pend && !i_flush) begin
          w_state_nxt  = RD_REQ;
          w_issue      = 1'b1;
          w_issue_pend = 1'b1;
          w_issue_addr = r_pend_addr;
        end
      end
      RD_REQ:  if (i_mem_gnt)    w_state_nxt = RD_WAIT;
      RD_WAIT: if (i_mem_rvalid) w_state_nxt = IDLE;
      WR_REQ:  if (i_mem_gnt)    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and registered memory-side outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == RD_REQ) || (w_state_nxt == WR_REQ);
      if (w_issue) begin
        r_we   <= w_issue_we;
        r_addr <= w_issue_addr;
        r_be   <= '1;
      end
      if (w_issue_we) r_wdata <= i_wr_data;
    end
  end

  // Pending read, drop flag and read buffer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend       <= 1'b0;
      r_pend_addr  <= '0;
      r_drop       <= 1'b0;
      r_rbuf_valid <= 1'b0;
      r_rbuf       <= '0;
    end else begin
      if (i_rd_start && (r_state != IDLE)) begin
        r_pend      <= 1'b1;
        r_pend_addr <= i_rd_addr;
      end else if (i_flush || w_issue_pend) begin
        r_pend      <= 1'b0;
      end

      if ((r_state == RD_WAIT) && i_mem_rvalid) r_drop <= 1'b0;
      else if (i_flush && w_outstanding)       r_drop <= 1'b1;

      if (i_flush) begin
        r_rbuf_valid <= 1'b0;
      end else if (w_rd_done) begin
        r_rbuf_valid <= 1'b1;
        r_rbuf       <= i_mem_rdata;
      end
    end
  end

endmodule

// File: rtl/jtag_mem_bridge.sv
// JTAG user-register to memory bridge: shift register, bit counter and
// address stepping; memory handshake lives in jtag_mem_req_fsm.
module jtag_mem_bridge
  import jtag_mem_pkg::*;
#(
  parameter  int unsigned DATA_W = 64,
  parameter  int unsigned ADDR_W = 32,
  localparam int unsigned CNT_W  = $clog2(DATA_W) + 1
) (
  input  logic                i_tck,
  input  logic                i_reset,
  input  logic                i_sel,
  input  logic                i_capture,
  input  logic                i_shift,
  input  logic                i_update,
  input  logic                i_tdi,
  output logic                o_tdo,
  input  logic                i_wr,
  input  logic                i_inc,
  input  logic [ADDR_W-1:0]   i_addr0,
  output logic                o_mem_req,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_be,
  input  logic                i_mem_gnt,
  input  logic                i_mem_rvalid,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_err
);

  localparam int unsigned       ERR_BIT = err_bit_pos(DATA_W);
  localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(DATA_W / 8);

  logic [DATA_W-1:0] r_sr;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic              r_err;

  logic              w_capture;
  logic              w_shift;
  logic              w_update;
  logic              w_boundary;
  logic              w_wr_bnd;
  logic              w_rd_bnd;
  logic              w_fsm_idle;
  logic              w_rbuf_valid;
  logic [DATA_W-1:0] w_rbuf;
  logic              w_rd_bypass;
  logic              w_wr_start;
  logic              w_overrun;
  logic              w_underrun;
  logic              w_rd_start;
  logic              w_flush;
  logic [ADDR_W-1:0] w_addr_adv;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_cap_word;
  logic [DATA_W-1:0] w_rd_word;

  assign w_capture  = i_sel && i_capture;
  assign w_shift    = i_sel && i_shift && !i_capture;
  assign w_update   = i_sel && i_update && !i_capture && !i_shift;
  assign w_shifted  = {i_tdi, r_sr[DATA_W-1:1]};
  assign w_boundary = w_shift && (r_cnt == CNT_W'(DATA_W - 1));
  assign w_wr_bnd   = w_boundary && r_wr;
  assign w_rd_bnd   = w_boundary && !r_wr;

  assign w_addr_adv = i_inc ? (r_addr + STRIDE) : r_addr;
  assign w_wr_start = w_wr_bnd && w_fsm_idle;
  assign w_overrun  = w_wr_bnd && !w_fsm_idle;
  assign w_underrun = w_rd_bnd && !w_rbuf_valid && !w_rd_bypass;
  assign w_rd_start = (w_capture && !i_wr) || w_rd_bnd;
  assign w_rd_addr  = w_capture ? i_addr0 : w_addr_adv;
  assign w_flush    = w_capture || w_rd_bnd;

  assign o_tdo      = r_sr[0];
  assign o_err      = r_err;

  // Capture word and the word loaded at a read boundary
  always_comb begin
    w_cap_word              = '0;
    w_cap_word[ADDR_W-1:0]  = i_addr0;
    w_cap_word[ERR_BIT]     = r_err;
    if (w_rbuf_valid)     w_rd_word = w_rbuf;
    else if (w_rd_bypass) w_rd_word = i_mem_rdata;
    else                  w_rd_word = {DATA_W{UNDERRUN_FILL}};
  end

  // Shift register, counter, address and sticky error
  always_ff @(posedge i_tck) begin
    if (i_reset) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_addr <= '0;
      r_wr   <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_capture) begin
      r_sr   <= w_cap_word;
      r_cnt  <= '0;
      r_addr <= i_addr0;
      r_wr   <= i_wr;
      r_err  <= 1'b0;
    end else if (w_shift) begin
      if (w_boundary) begin
        r_cnt <= '0;
        r_sr  <= r_wr ? w_shifted : w_rd_word;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        r_sr  <= w_shifted;
      end
      if (w_rd_bnd || (w_wr_start && i_inc)) r_addr <= w_addr_adv;
      if (w_overrun || w_underrun)           r_err  <= 1'b1;
    end else if (w_update) begin
      r_cnt <= '0;
    end
  end

  jtag_mem_req_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_req_fsm (
    .i_clk        (i_tck),
    .i_rst        (i_reset),
    .i_rd_start   (w_rd_start),
    .i_rd_addr    (w_rd_addr),
    .i_wr_start   (w_wr_start),
    .i_wr_addr    (r_addr),
    .i_wr_data    (w_shifted),
    .i_flush      (w_flush),
    .o_idle       (w_fsm_idle),
    .o_rbuf_valid (w_rbuf_valid),
    .o_rbuf       (w_rbuf),
    .o_rd_bypass  (w_rd_bypass),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_be     (o_mem_be),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata)
  );

endmodule

// File: doc/jtag_mem_bridge.md
Name: jtag_mem_bridge

Overview:
- Parametrised JTAG-to-memory bridge, clocked on TCK, driven by the BSCANE2 user-register TAP signals.
- Successor to the fixed 64-bit JTAG ROM access block. Adds configurable data and address width, a request/grant/rvalid memory handshake instead of combinational read data, and read prefetch.
- Adds byte-strobe generation, a stride-correct address increment and a sticky error flag reported through the capture word.
- Sits between the debug TAP and an on-chip RAM/ROM port, for bulk load and dump over JTAG.

Parameters:
- DATA_W, 64: shift-register and memory word width in bits; multiple of 8; must be at least 16.
- ADDR_W, 32: byte address width; constraint ADDR_W <= DATA_W-1.
- CNT_W, $clog2(DATA_W)+1: bit-counter width (derived; not overridden).

Ports:
- TCK  in  1  clock; all state changes on posedge.
- RESET  in  1  synchronous, active-high reset (TAP test-logic-reset).
- SEL  in  1  user instruction selected.
- CAPTURE  in  1  capture-DR.
- SHIFT  in  1  shift-DR.
- UPDATE  in  1  update-DR.
- TDI  in  1  serial in.
- TDO  out  1  serial out = SR[0].
- WR  in  1  1 = write scan, 0 = read scan; sampled on CAPTURE, held for the scan.
- INC  in  1  advance address by DATA_W/8 after each word.
- ADDR0  in  ADDR_W  start byte address; sampled on CAPTURE.
- MEM_REQ  out  1  request; held until MEM_GNT.
- MEM_WE  out  1  write enable; valid while MEM_REQ.
- MEM_ADDR  out  ADDR_W  byte address; valid while MEM_REQ.
- MEM_WDATA  out  DATA_W  write data.
- MEM_BE  out  DATA_W/8  byte strobes; all ones on writes, all ones on reads.
- MEM_GNT  in  1  request accepted this cycle.
- MEM_RVALID  in  1  read data valid; arrives 1 or more cycles after GNT.
- MEM_RDATA  in  DATA_W  read data.
- ERR  out  1  sticky error flag; also exposed in the capture word.

Behaviour:
- Reset: MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE, ERR, SR, CNT, read buffer and its valid bit all 0; FSM = IDLE.
- RESET mid-transaction: MEM_REQ drops on the same edge. A later MEM_RVALID is ignored.
- FSM states:
  - IDLE to RD_REQ: read scan at CAPTURE, or a read word boundary.
  - IDLE to WR_REQ: write word boundary.
  - RD_REQ to RD_WAIT: on GNT.
  - RD_WAIT to IDLE: on RVALID. MEM_RDATA is latched into RBUF and RBUF valid is set.
  - WR_REQ to IDLE: on GNT.
- MEM_REQ is registered: asserted the cycle after the triggering edge.
- CAPTURE (SEL=1):
  - SR <= {ERR, zero pad, ADDR0}; CNT <= 0; address register <= ADDR0.
  - RBUF valid cleared.
  - Read scans issue a prefetch read at ADDR0.
  - ERR is cleared after being captured.
- SHIFT (SEL=1):
  - SR <= {TDI, SR[DATA_W-1:1]}; CNT++.
  - When CNT reaches DATA_W (word boundary), CNT <= 0.
- Write boundary:
  - If FSM is IDLE: MEM_WDATA <= the shifted word (including the boundary bit); WR_REQ is entered at the current address; the address then advances if INC.
  - If FSM is not IDLE (overrun): the word is dropped and ERR is set.
- Read boundary:
  - If RBUF is valid: SR <= RBUF.
  - If MEM_RVALID is asserted in this same cycle: SR <= MEM_RDATA (bypass).
  - Otherwise (underrun): SR <= all ones and ERR is set.
  - In every case RBUF valid is cleared. The address advances by DATA_W/8 if INC. The next prefetch issues at the new address; without INC the same address is re-read.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- UPDATE with CNT != 0 on a write scan: the partial word is discarded and no write is issued.
- UPDATE with CNT == 0: no effect.
- UPDATE always resets CNT.
- SEL = 0:
  - SR and CNT are frozen.
  - An outstanding memory transaction completes; its read data goes to RBUF.
  - A new CAPTURE while a read is outstanding discards that data on arrival (tracked by a drop-flag).
- First word of a read scan: SR holds the capture word. Memory data appears from the second DATA_W shifts onward.

Decomposition:
- Package jtag_mem_pkg holds:
  - the FSM state enum (IDLE, RD_REQ, RD_WAIT, WR_REQ);
  - the capture-word field positions (ERR_BIT = DATA_W-1);
  - the underrun fill constant (all ones).
- One natural sub-module: jtag_mem_req_fsm, which owns the request/grant/rvalid handshake, RBUF and the drop-flag. The shift register and counter stay in the top level.

Test Plan:
- Write scan: ADDR0=0x1000, INC=1, three words, GNT 1 cycle after REQ -> writes 0x1000/0x1008/0x1010 with exact words, MEM_BE=0xFF, ERR=0.
- Read scan: memory returns addr^0xA5A5 with RVALID 3 cycles after GNT, ADDR0=0x2000, INC=1 -> TDO gives {0,...,0x2000}, then the data for 0x2000 and then 0x2008, LSB first.
- Read underrun: RVALID delayed beyond 64 TCK -> word reads 0xFFFF_FFFF_FFFF_FFFF, ERR=1, next CAPTURE word bit63=1, then ERR=0.
- Write overrun: GNT withheld for 70 cycles -> second word dropped, single MEM_REQ per grant, ERR=1.
- INC=0 read, 2 words -> both reads at ADDR0. Address wrap: ADDR0=0xFFFF_FFF8, INC=1 -> second access at 0x0000_0000.
- RESET asserted while MEM_REQ is high -> MEM_REQ=0 next edge, a late RVALID is ignored; DATA_W=32/ADDR_W=16 build repeats the write-scan test with stride 4.
